// File: rtl/seq_mul.sv
// seq_mul: multi-cycle shift-add multiplier, unsigned or two's-complement
// signed per transaction. One product every WIDTH+2 cycles at best.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in DONE and, once raised, holds with p stable until out_ready.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     a, b, signed_mode valid this cycle
//   in_ready     block can accept operands (IDLE only)
//   a, b         WIDTH-bit multiplicand / multiplier
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   out_valid    p is valid, held until consumed
//   out_ready    consumer accepts p
//   p            2*WIDTH-bit product
//   state_dbg    current FSM state, for observation only
module seq_mul #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   ma_sh;   // multiplicand magnitude, pre-shifted by k
   logic [WIDTH-1:0]     mb;      // multiplier magnitude, consumed LSB first
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   acc_sum;
   logic                 last_iter;

   // The magnitude of the most negative value is 2^(WIDTH-1), which still
   // fits in WIDTH unsigned bits, so negation here never loses information.
   always_comb begin
      a_mag = a;
      b_mag = b;
      if (signed_mode && a[WIDTH-1]) a_mag = -a;
      if (signed_mode && b[WIDTH-1]) b_mag = -b;
   end

   assign acc_sum   = mb[0] ? (acc + ma_sh) : acc;
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ma_sh     <= '0;
         mb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         p         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ma_sh    <= {{WIDTH{1'b0}}, a_mag};
                  mb       <= b_mag;
                  neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc   <= acc_sum;
               ma_sh <= ma_sh << 1;
               mb    <= mb >> 1;
               cnt   <= cnt + CNT_W'(1);
               // The final iteration's sum goes straight to p, so the result
               // is visible exactly WIDTH edges after the accept edge.
               if (last_iter) begin
                  p         <= neg ? -acc_sum : acc_sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Input handshake cannot complete here: in_ready is low until
               // the edge that returns to IDLE.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Parametrised, multi-cycle shift-add multiplier; the successor to the fixed 2-bit combinational multiplier.
- Takes two WIDTH-bit operands through a valid/ready handshake and returns a 2*WIDTH-bit product after a fixed latency of WIDTH cycles.
- Supports unsigned and two's-complement signed operation, selected per transaction.
- Sits between operand registers/switch inputs and display/accumulate logic in lab datapaths.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b and signed_mode are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a and b as two's complement; 0 = unsigned.
- out_valid  output  1  product is valid; held until consumed.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (first cycle after reset), out_valid=0, p=0, internal accumulator/counter=0.
- Reset mid-operation: any in-flight or unconsumed result is discarded; the block returns to IDLE on the next edge with the values above.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, latch the operands and go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Performs one iteration per cycle; after WIDTH iterations goes to DONE.
  - DONE: out_valid=1 and p stable. On an edge with out_ready=1, go to IDLE (out_valid=0).
- Accept edge, on in_valid & in_ready:
  - Store ma = |a| and mb = |b|, each as WIDTH-bit unsigned magnitude; abs is applied only when signed_mode=1.
  - Store neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH-bit accumulator; set counter=0.
- BUSY iteration k (k=0..WIDTH-1):
  - If mb[0], acc += ma << k.
  - Then mb >>= 1 and counter += 1.
  - Fixed latency; no early termination on zero operands.
- Leaving BUSY: on the edge where counter reaches WIDTH, p <= neg ? -acc : acc (2*WIDTH-bit two's complement), state <= DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge. Throughput is one product per WIDTH+2 cycles minimum (accept, WIDTH busy, 1 drain cycle in DONE with out_ready=1).
- Back-pressure: with out_ready=0, DONE holds indefinitely; p and out_valid stay stable, and in_ready stays 0.
- No overlap: operands presented while not in IDLE are ignored and not queued. The a, b and signed_mode inputs are sampled only on the accept edge; later changes have no effect.
- Width rules:
  - Unsigned: p = a*b, exact, range 0..(2^WIDTH-1)^2.
  - Signed: p = a*b, exact, in 2*WIDTH-bit two's complement.
  - Most-negative operand: abs(-2^(WIDTH-1)) = 2^(WIDTH-1) fits as an unsigned magnitude, so (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is exact.
- Zero result with neg=1 yields p=0 (negation of 0).
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The operand is accepted in the following IDLE cycle if in_valid is still high.

Test Plan:
1. Unsigned basic, WIDTH=8: rst held 2 cycles, then a=13, b=11, signed_mode=0, in_valid 1 cycle -> in_ready drops next cycle; out_valid rises exactly 8 cycles after accept; p=16'd143.
2. Signed corners, WIDTH=8, signed_mode=1:
   - a=-3 (8'hFD), b=7 -> p=16'hFFEB (-21).
   - a=-128, b=-128 -> p=16'h4000.
   - a=-128, b=127 -> p=16'hC080 (-16256).
   - a=0, b=-5 -> p=0.
3. Unsigned extremes: a=8'hFF, b=8'hFF, signed_mode=0 -> p=16'hFE01; same operands with signed_mode=1 -> p=16'h0001.
4. Back-pressure and input hold-off: hold out_ready=0 for 20 cycles after out_valid -> p and out_valid stable, in_ready=0; change a/b and pulse in_valid during BUSY and DONE -> ignored, result unchanged; raise out_ready -> out_valid low next cycle, in_ready high.
5. Reset mid-operation: accept a=200, b=3; assert rst at BUSY cycle 4 -> next edge out_valid=0, p=0, in_ready=1. A new transaction a=5, b=6 completes with p=30 after 8 cycles.
6. Parameter sweep plus random: WIDTH=2, 4, 16, with 1000 random transactions each, random signed_mode and random out_ready stalls -> every p matches a reference product (mod 2^(2*WIDTH)). Latency is always WIDTH, and no result is dropped or duplicated.
